// File: rtl/serial_deserializer_pkg.sv
// ============================================================================
// serial_deserializer_pkg : shared FSM encodings and defaults | Rev 1.0
// ============================================================================
`default_nettype none

package serial_deserializer_pkg;

   localparam int DESER_WIDTH_DEF = 8;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } deser_state_t;

endpackage : serial_deserializer_pkg

`default_nettype wire

// File: rtl/serial_deserializer_if.sv
// ============================================================================
// serial_deserializer_if : serial bit input and word valid/ready output | Rev 1.0
// ============================================================================
`default_nettype none

interface serial_deserializer_if #(
   parameter int WIDTH = 8
);
   logic             din;
   logic             din_en;
   logic             sync;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             overflow;
   logic             clr_ovf;

   modport master (
      output din, din_en, sync, dout_ready, clr_ovf,
      input  dout, dout_valid, overflow
   );

   modport slave (
      input  din, din_en, sync, dout_ready, clr_ovf,
      output dout, dout_valid, overflow
   );
endinterface : serial_deserializer_if

`default_nettype wire

// File: rtl/serial_deserializer_shift_reg.sv
// ============================================================================
// deser_shift_reg : serial-in shift register, exposes next-cycle word | Rev 1.0
// ============================================================================
`default_nettype none

module deser_shift_reg #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             din,
   input  logic             clr,
   output logic [WIDTH-1:0] word_nxt
);
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] w_base;
   logic [WIDTH-1:0] w_shifted;

   // clr and en together means the incoming bit is the first of a fresh word
   always_comb w_base = clr ? '0 : r_sr;

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         always_comb w_shifted = {w_base[WIDTH-2:0], din};
      end else begin : g_lsb_first
         always_comb w_shifted = {din, w_base[WIDTH-1:1]};
      end
   endgenerate

   always_comb word_nxt = en ? w_shifted : w_base;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr <= '0;
      end else begin
         r_sr <= word_nxt;
      end
   end
endmodule : deser_shift_reg

`default_nettype wire

// File: rtl/serial_deserializer.sv
// ============================================================================
// serial_deserializer : frames serial bits into words, one-entry output hold | Rev 1.0
// ============================================================================
`default_nettype none

module serial_deserializer
   import serial_deserializer_pkg::*;
#(
   parameter int WIDTH      = DESER_WIDTH_DEF,
   parameter int MSB_FIRST  = 1,
   parameter int CONTINUOUS = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_deserializer_if.slave  bus
);
   localparam int             CW     = $clog2(WIDTH);
   localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

   deser_state_t     r_state, w_state_nxt;
   logic [CW-1:0]    r_count, w_count_nxt;
   logic             w_complete;
   logic             w_take;
   logic [WIDTH-1:0] w_word_nxt;
   logic [WIDTH-1:0] r_dout;
   logic             r_valid;
   logic             r_overflow;

   assign w_take = bus.din_en && (bus.sync || (r_state == ST_SHIFT));

   deser_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (w_take),
      .din      (bus.din),
      .clr      (bus.sync),
      .word_nxt (w_word_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   // sync outranks completion: a restart on the last bit never emits a word
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_complete  = 1'b0;
      if (bus.sync) begin
         w_state_nxt = ST_SHIFT;
         w_count_nxt = bus.din_en ? CW'(1) : '0;
      end else if ((r_state == ST_SHIFT) && bus.din_en) begin
         if (r_count == c_last) begin
            w_complete  = 1'b1;
            w_count_nxt = '0;
            w_state_nxt = (CONTINUOUS != 0) ? ST_SHIFT : ST_IDLE;
         end else begin
            w_count_nxt = r_count + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout     <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_complete && (!r_valid || bus.dout_ready)) begin
            r_dout  <= w_word_nxt;
            r_valid <= 1'b1;
         end else if (r_valid && bus.dout_ready) begin
            r_valid <= 1'b0;
         end

         if (w_complete && r_valid && !bus.dout_ready) begin
            r_overflow <= 1'b1;
         end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_valid;
   assign bus.overflow   = r_overflow;
endmodule : serial_deserializer

`default_nettype wire
